// File: rtl/serial_link_pkg.sv
// Shared definitions for the nibble serial link: data width, sender frame timing and
// the feeder FSM state encoding.
package serial_link_pkg;

  localparam int unsigned DATA_W       = 4;
  localparam int unsigned FRAME_CYCLES = 6;
  // Wide enough for FRAME_CYCLES + the largest GAP (7).
  localparam int unsigned WAIT_W       = $clog2(FRAME_CYCLES + 8);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait
  } tx_state_e;

  // Counter preload so consecutive launches land FRAME_CYCLES + gap edges apart.
  function automatic logic [WAIT_W-1:0] wait_load(input int unsigned gap);
    return WAIT_W'(FRAME_CYCLES + gap - 2);
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Power-of-two circular FIFO holding nibbles queued for the serial sender.
// Writes while full are dropped; the occupancy count is kept explicitly.
module nibble_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rptr_q];

  assign push = wr_en && !full && !reset;
  assign pop  = rd_en && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/tx_feeder.sv
// Drains the nibble FIFO into the serial sender: one start pulse per nibble, spaced so the
// sender has finished its frame plus GAP idle cycles before the next launch.
module tx_feeder
  import serial_link_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              inValid,
  output logic              inReady,
  output logic              start,
  output logic [DATA_W-1:0] dataOut,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  tx_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] head;

  nibble_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inValid),
    .wr_data (dataIn),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign inReady = !fifo_full;
  assign start   = start_q;
  assign dataOut = data_q;
  assign busy    = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    start_d = start_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = head;
          start_d = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        start_d = 1'b0;
        wait_d  = wait_load(GAP);
        state_d = StWait;
      end
      StWait: begin
        // Leave as the counter reaches zero so IDLE can relaunch on the very next edge.
        wait_d = wait_q - 1'b1;
        if (wait_q <= WAIT_W'(1)) begin
          wait_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_tx_feeder.sv
// Directed bench for tx_feeder: a cycle table for the single-nibble path, then hand
// sequences for back-to-back frames, overflow, mid-frame reset and GAP=0 streaming.
module tb_tx_feeder;

  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, in_valid = 1'b0, in_ready, start, busy;
  logic [3:0]    data_in = 4'h0, data_out;
  logic [CW-1:0] count;

  logic          reset_g0 = 1'b1, in_valid_g0 = 1'b0, in_ready_g0, start_g0, busy_g0;
  logic [3:0]    data_in_g0 = 4'h0, data_out_g0;
  logic [CW-1:0] count_g0;

  tx_feeder #(.DEPTH(4), .GAP(1)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .dataIn  (data_in),
    .inValid (in_valid),
    .inReady (in_ready),
    .start   (start),
    .dataOut (data_out),
    .count   (count),
    .busy    (busy)
  );

  tx_feeder #(.DEPTH(4), .GAP(0)) u_dut_g0 (
    .clk     (clk),
    .reset   (reset_g0),
    .dataIn  (data_in_g0),
    .inValid (in_valid_g0),
    .inReady (in_ready_g0),
    .start   (start_g0),
    .dataOut (data_out_g0),
    .count   (count_g0),
    .busy    (busy_g0)
  );

  typedef struct {
    logic          rst;
    logic          vld;
    logic [3:0]    din;
    logic          e_start;
    logic [3:0]    e_dout;
    logic [CW-1:0] e_count;
    logic          e_busy;
    logic          e_ready;
  } vec_t;

  vec_t vecs[11];

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int         launch_cyc[$];
  logic [3:0] launch_dat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic [3:0] d);
    reset    = r;
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    #1;
    cycle++;
    if (start === 1'b1) begin
      launch_cyc.push_back(cycle);
      launch_dat.push_back(data_out);
    end
  endtask

  task automatic clear_log();
    launch_cyc.delete();
    launch_dat.delete();
  endtask

  int p;
  logic [3:0] exp_c[5];
  int         g0_cyc[$];
  logic [3:0] g0_dat[$];
  logic [3:0] pushed[$];
  logic [3:0] nxt;
  logic       acc;

  initial begin
    // rst vld din | start dout count busy ready
    vecs[0]  = '{1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 3'd1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'hA, 3'd0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 3'd0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 3'd0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 3'd0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 3'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 3'd0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 3'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 3'd0, 1'b0, 1'b1};

    #2;
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].din);
      check($sformatf("vec%0d{start,dout,count,busy,ready}", i),
            {start, data_out, count, busy, in_ready},
            {vecs[i].e_start, vecs[i].e_dout, vecs[i].e_count, vecs[i].e_busy, vecs[i].e_ready});
    end

    // Back-to-back pushes: launches at P+1, P+8, P+15 carrying 1, 2, 3.
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    clear_log();
    step(1'b0, 1'b1, 4'h1);
    p = cycle;
    step(1'b0, 1'b1, 4'h2);
    check("b2b_push_pop_count", 32'(count), 32'd1);
    step(1'b0, 1'b1, 4'h3);
    check("b2b_count", 32'(count), 32'd2);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'h0);
    check("b2b_launches", 32'(launch_cyc.size()), 32'd3);
    if (launch_cyc.size() == 3) begin
      check("b2b_first_latency", 32'(launch_cyc[0] - p), 32'd1);
      check("b2b_space0", 32'(launch_cyc[1] - launch_cyc[0]), 32'd7);
      check("b2b_space1", 32'(launch_cyc[2] - launch_cyc[1]), 32'd7);
      check("b2b_data", {launch_dat[0], launch_dat[1], launch_dat[2]}, 32'h123);
    end
    check("b2b_end_idle", {busy, count}, 32'd0);

    // Overflow: fill four entries while the first frame is in flight, fifth is dropped.
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    clear_log();
    step(1'b0, 1'b1, 4'hB);
    step(1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check("full_ready", 32'(in_ready), 32'd0);
      step(1'b0, 1'b1, 4'(4 + k));
    end
    check("full_count", 32'(count), 32'd4);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 4'h0);
    exp_c = '{4'hB, 4'h4, 4'h5, 4'h6, 4'h7};
    check("full_launches", 32'(launch_dat.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < launch_dat.size())
        check($sformatf("full_order%0d", i), 32'(launch_dat[i]), 32'(exp_c[i]));
    end
    check("full_drained", 32'(count), 32'd0);

    // Reset three cycles after the first start, with two entries queued.
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h1);
    step(1'b0, 1'b1, 4'h2);
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b0, 4'h0);
    check("rst_pre_count", 32'(count), 32'd2);
    step(1'b1, 1'b0, 4'h0);
    check("rst_abort", {start, data_out, count, busy, in_ready}, 32'h001);
    clear_log();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'h0);
    check("rst_no_launch", 32'(launch_cyc.size()), 32'd0);

    // GAP=0 continuous feed on the second instance.
    in_valid_g0 = 1'b0;
    @(posedge clk);
    #1;
    reset_g0 = 1'b0;
    nxt = 4'h0;
    for (int c = 0; c < 40; c++) begin
      acc = in_ready_g0;
      in_valid_g0 = 1'b1;
      data_in_g0  = nxt;
      @(posedge clk);
      #1;
      if (acc) begin
        pushed.push_back(nxt);
        nxt = nxt + 4'h1;
      end
      if (start_g0 === 1'b1) begin
        g0_cyc.push_back(c);
        g0_dat.push_back(data_out_g0);
      end
    end
    in_valid_g0 = 1'b0;
    check("g0_launches", 32'(g0_cyc.size() >= 5), 32'd1);
    for (int i = 1; i < g0_cyc.size(); i++)
      check($sformatf("g0_space%0d", i), 32'(g0_cyc[i] - g0_cyc[i-1]), 32'd6);
    for (int i = 0; i < g0_dat.size(); i++) begin
      if (i < pushed.size())
        check($sformatf("g0_data%0d", i), 32'(g0_dat[i]), 32'(pushed[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
